// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants, coordinate type and small helpers.
// Defaults describe 640x480 at a 25 MHz pixel rate from a 100 MHz clock.
package vga_timing_pkg;

  // Coordinate and frame-counter widths seen on the raster interface
  localparam int COORD_W = 10;
  localparam int FRAME_W = 8;

  // Default pixel-rate divider and move-strobe divider
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_MOVE_DIV = 1;

  // Default horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Derived totals for the default mode
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // True when v lies in the inclusive window [lo, hi]
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Free-running clock-enable generator: one registered single-cycle pulse
// every CLK_DIV clocks. The first pulse after reset lands in the CLK_DIV-th
// cycle, and the pulse is never high on two consecutive cycles (CLK_DIV >= 2).
module clk_en_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pixpulse
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pixpulse_q, pixpulse_d;

  // Next divider phase; the enable is registered so it tracks div == CLK_DIV-1 exactly
  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pixpulse_d = (div_d == DIV_LAST);
  end

  // Divider phase and enable registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      pixpulse_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pixpulse_q <= pixpulse_d;
    end
  end

  assign pixpulse = pixpulse_q;

endmodule

// File: rtl/vga_raster_timer.sv
// Raster scan producer: pixel enable, hcount/vcount, sync/blank, frame counter
// and the per-frame move strobe sampled by the sprite and asteroid blocks.
// Every output comes straight from a register.
module vga_raster_timer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int MOVE_DIV = DEF_MOVE_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  output logic               pixpulse,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               move,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Coordinate-width landmarks so every compare is width-matched
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Move-divider counter runs 0..MOVE_DIV-1
  localparam int               MDIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [MDIV_W-1:0] MDIV_LAST = MDIV_W'(MOVE_DIV - 1);

  logic   pix;
  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;
  frame_t frame_cnt_q, frame_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   blank_q, blank_d;
  logic   move_q, move_d;
  logic   [MDIV_W-1:0] mdiv_q, mdiv_d;
  logic   vblank_start;

  clk_en_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pixpulse (pix)
  );

  // Raster counters: advance once per pixel enable, carrying h -> v -> frame
  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    if (pix) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d    = '0;
          frame_cnt_d = frame_cnt_q + frame_t'(1);
        end else begin
          vcount_d = vcount_q + coord_t'(1);
        end
      end else begin
        hcount_d = hcount_q + coord_t'(1);
      end
    end
  end

  // Sync and blank decoded from next-state counts so they line up with hcount/vcount
  always_comb begin
    hsync_d = ~in_span(hcount_d, HS_FIRST, HS_LAST);
    vsync_d = ~in_span(vcount_d, VS_FIRST, VS_LAST);
    blank_d = (hcount_d >= H_ACT) || (vcount_d >= V_ACT);
  end

  // Move strobe: decided when the counts step onto (0, V_ACTIVE), held until the next pixel enable
  always_comb begin
    move_d       = move_q;
    mdiv_d       = mdiv_q;
    vblank_start = pix && (hcount_q == H_LAST) && (vcount_d == V_ACT);
    if (pix) begin
      move_d = 1'b0;
    end
    if (vblank_start && !pause) begin
      if (mdiv_q == MDIV_LAST) begin
        move_d = 1'b1;
        mdiv_d = '0;
      end else begin
        mdiv_d = mdiv_q + MDIV_W'(1);
      end
    end
  end

  // State and output registers, forced to idle values the moment rst rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_q     <= 1'b0;
      move_q      <= 1'b0;
      mdiv_q      <= '0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
      move_q      <= move_d;
      mdiv_q      <= mdiv_d;
    end
  end

  assign pixpulse  = pix;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign frame_cnt = frame_cnt_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign move      = move_q;

endmodule

// File: tb/tb_vga_raster_timer.sv
// Bench for vga_raster_timer using a reduced raster (24x16) so several frames
// fit in a few thousand clocks. Two instances: MOVE_DIV=1 with pause exercised,
// and MOVE_DIV=2 free running. A closed-form model indexed by clock edges
// since reset pushes expected output vectors; the negedge checker pops them.
module tb_vga_raster_timer;

  localparam int CLK_DIV = 4;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 10, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int MD_A = 1;
  localparam int MD_B = 2;

  // {pixpulse, hcount, vcount, hsync, vsync, blank, move, frame_cnt}
  localparam logic [32:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  logic clk = 1'b0;
  logic rst;
  logic pause_a, pause_b;

  logic       pp_a, hs_a, vs_a, bl_a, mv_a;
  logic [9:0] hc_a, vc_a;
  logic [7:0] fc_a;
  logic       pp_b, hs_b, vs_b, bl_b, mv_b;
  logic [9:0] hc_b, vc_b;
  logic [7:0] fc_b;

  always #5 clk = ~clk;

  vga_raster_timer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(MD_A)
  ) dut_a (
    .clk(clk), .rst(rst), .pause(pause_a), .pixpulse(pp_a), .hcount(hc_a),
    .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .move(mv_a),
    .frame_cnt(fc_a)
  );

  vga_raster_timer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(MD_B)
  ) dut_b (
    .clk(clk), .rst(rst), .pause(pause_b), .pixpulse(pp_b), .hcount(hc_b),
    .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .move(mv_b),
    .frame_cnt(fc_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after `edges` rising edges since reset release
  function automatic logic [32:0] model_vec(input int unsigned edges, input logic mv);
    int unsigned p, hc, vc, fc;
    logic pp, hs, vs, bl;
    p  = edges / CLK_DIV;
    hc = p % HT;
    vc = (p / HT) % VT;
    fc = (p / FT) % 256;
    pp = ((edges % CLK_DIV) == CLK_DIV - 1);
    hs = !((hc >= HA + HF) && (hc <= HA + HF + HS - 1));
    vs = !((vc >= VA + VF) && (vc <= VA + VF + VS - 1));
    bl = (hc >= HA) || (vc >= VA);
    return {pp, 10'(hc), 10'(vc), hs, vs, bl, mv, 8'(fc)};
  endfunction

  // Reference model and scoreboard producer
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int unsigned edges;
  int unsigned eva, evb;
  logic        mva, mvb;

  always @(posedge clk) begin
    if (rst) begin
      edges = 0; eva = 0; evb = 0; mva = 1'b0; mvb = 1'b0;
      qa.push_back(RST_VEC);
      qb.push_back(RST_VEC);
    end else begin
      edges++;
      if ((edges % CLK_DIV) == 0) begin
        mva = 1'b0;
        mvb = 1'b0;
        if (((edges / CLK_DIV) % FT) == VA * HT) begin
          if (!pause_a) begin eva++; mva = ((eva % MD_A) == 0); end
          if (!pause_b) begin evb++; mvb = ((evb % MD_B) == 0); end
        end
      end
      qa.push_back(model_vec(edges, mva));
      qb.push_back(model_vec(edges, mvb));
    end
  end

  // Scoreboard consumer, away from the active edge
  logic [32:0] ea, eb;
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("vec_a", {pp_a, hc_a, vc_a, hs_a, vs_a, bl_a, mv_a, fc_a}, ea);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("vec_b", {pp_b, hc_b, vc_b, hs_b, vs_b, bl_b, mv_b, fc_b}, eb);
    end
  end

  // Aggregate monitors on dut_a / dut_b outputs
  int pix_cnt = 0, hs_lo = 0, vs_lo = 0, bl_cnt = 0;
  int mva_cnt = 0, mvb_cnt = 0, wa = 0, wb = 0, ova = 0, ovb = 0;
  always @(negedge clk) begin
    if (pp_a === 1'b1) begin
      pix_cnt++;
      if (hs_a === 1'b0) hs_lo++;
      if (vs_a === 1'b0) vs_lo++;
      if (bl_a === 1'b1) bl_cnt++;
    end
    if (mv_a === 1'b1) begin
      if (wa == 0) mva_cnt++;
      wa++;
      if (pp_a === 1'b1) ova++;
    end else if (wa != 0) begin
      chk("move_width_a", wa, CLK_DIV);
      chk("move_pix_overlap_a", ova, 1);
      wa = 0; ova = 0;
    end
    if (mv_b === 1'b1) begin
      if (wb == 0) mvb_cnt++;
      wb++;
      if (pp_b === 1'b1) ovb++;
    end else if (wb != 0) begin
      chk("move_width_b", wb, CLK_DIV);
      chk("move_pix_overlap_b", ovb, 1);
      wb = 0; ovb = 0;
    end
  end

  task automatic wait_fc(input logic [7:0] target, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (fc_a == target) found = 1'b1;
    end
    chk($sformatf("reach_frame_%0d", target), found, 1);
  endtask

  initial begin
    bit found;
    int n;
    rst = 1'b1;
    pause_a = 1'b0;
    pause_b = 1'b0;
    #1;
    chk("reset_a", {pp_a, hc_a, vc_a, hs_a, vs_a, bl_a, mv_a, fc_a}, RST_VEC);
    chk("reset_b", {pp_b, hc_b, vc_b, hs_b, vs_b, bl_b, mv_b, fc_b}, RST_VEC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Frames 0 and 1 free running, frame 2 paused on dut_a, frame 3 free again
    wait_fc(8'd2, 3 * FT * CLK_DIV);
    pause_a = 1'b1;
    wait_fc(8'd3, 2 * FT * CLK_DIV);
    pause_a = 1'b0;
    wait_fc(8'd4, 2 * FT * CLK_DIV);
    #1;
    chk("pixpulses_4_frames", pix_cnt, 4 * FT);
    chk("hsync_low_pixels", hs_lo, 4 * VT * HS);
    chk("vsync_low_pixels", vs_lo, 4 * VS * HT);
    chk("blank_pixels", bl_cnt, 4 * (FT - HA * VA));
    chk("move_pulses_a", mva_cnt, 3);
    chk("move_pulses_b", mvb_cnt, 2);

    // Asynchronous reset in the middle of a line
    found = 1'b0;
    for (int i = 0; i < FT * CLK_DIV && !found; i++) begin
      @(negedge clk);
      if (hc_a == 10'd12 && vc_a == 10'd5) found = 1'b1;
    end
    chk("reach_mid_frame", found, 1);
    #1;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("async_rst_a", {pp_a, hc_a, vc_a, hs_a, vs_a, bl_a, mv_a, fc_a}, RST_VEC);
    chk("async_rst_b", {pp_b, hc_b, vc_b, hs_b, vs_b, bl_b, mv_b, fc_b}, RST_VEC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First pixel enable after release lands in clk cycle CLK_DIV
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * CLK_DIV && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (pp_a === 1'b1) found = 1'b1;
    end
    chk("first_pix_cycle", n + 1, CLK_DIV);
    repeat (2 * HT * CLK_DIV) @(negedge clk);
    #1;
    chk("restart_vcount", vc_a, 2);
    chk("restart_frame", fc_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_raster_timer.md
Name: vga_raster_timer

Overview:
Generates the pixel-rate enable and the raster scan coordinates consumed by every sprite and asteroid block: pixpulse, hcount and vcount. It also drives the monitor sync and blank signals and the frame-rate move strobe that steps object positions. It is the producer end of the raster interface that the asteroid/ship blocks sample. It sits at top level, alongside the pixel compositor.

Parameters:
CLK_DIV, 4, clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch in lines
MOVE_DIV, 1, frames per move strobe; must be >= 1

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset: asynchronous, active-high
pause  in  1  suppresses the move strobe; raster timing keeps running
pixpulse  out  1  one-clk enable, one per pixel period
hcount  out  10  current x position, 0..H_TOTAL-1
vcount  out  10  current y position, 0..V_TOTAL-1
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
blank  out  1  high outside the visible area
move  out  1  position-update strobe
frame_cnt  out  8  completed-frame counter, wraps at 255 to 0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- All outputs are registered.
- Reset values (applied immediately on rst, including mid-frame):
  - pixpulse=0, hcount=0, vcount=0, hsync=1, vsync=1, blank=0, move=0, frame_cnt=0.
  - The internal divider and the move-divider counter are also cleared.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps; it increments every clk.
  - pixpulse is high in exactly the cycles where div==CLK_DIV-1.
  - After rst deasserts, the first pixpulse is the CLK_DIV-th clk cycle; after that the period is exactly CLK_DIV.
- Counters advance only on a clk edge at which pixpulse is high.
  - Consumers sampling on that same edge see the old coordinates.
  - hcount: H_TOTAL-1 wraps to 0.
  - On the same edge that hcount wraps, vcount increments; V_TOTAL-1 wraps to 0.
  - On the same edge that vcount wraps, frame_cnt increments.
- Sync and blank are computed from the next-state counts, so they are cycle-aligned with hcount/vcount:
  - hsync=0 iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vsync=0 iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
  - blank=1 iff hcount>=H_ACTIVE or vcount>=V_ACTIVE.
- Move strobe:
  - Event point: the pixpulse edge on which the counts become (hcount=0, vcount=V_ACTIVE), i.e. the start of vertical blanking.
  - Move-divider counter mdiv runs 0..MOVE_DIV-1.
  - At the event point with pause=0: if mdiv==MOVE_DIV-1, set move=1 and mdiv<=0; otherwise mdiv<=mdiv+1.
  - At the event point with pause=1: move stays 0 and mdiv holds.
  - move is cleared at the next pixpulse edge. It is therefore high for exactly CLK_DIV clk cycles and overlaps exactly one pixpulse cycle, so each consumer updates once per strobe.
  - pause changing while move is already high does not truncate the pulse.
- Simultaneous events: hcount wrap, vcount wrap and frame_cnt increment may all occur on one edge; all update together.
- No other state; there is no handshake. Consumers are pure listeners.

Decomposition:
- Package vga_timing_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL, and the 10-bit coordinate width.
- One sub-module, clk_en_divider (parameter CLK_DIV, outputs pixpulse), is shared with any other block needing the pixel enable.
- The counters, sync/blank logic and move logic stay in vga_raster_timer.

Test Plan:
- Release rst at t0 → pixpulse high first in clk cycle 4, then every 4 clks; never two consecutive cycles high.
- Run one line → hcount steps 0..799 once per pixpulse; at the 799→0 edge vcount goes 0→1. blank=1 for hcount 640..799; hsync low for exactly 96 pixpulses (hcount 656..751).
- Run one frame → vsync low exactly for vcount 490..491 (1600 pixpulses). vcount 524→0 coincides with hcount 799→0, and frame_cnt goes 0→1.
- MOVE_DIV=2, pause=0, run 4 frames → move high only at (0,480) of frames 1 and 3. Each pulse is 4 clks wide and overlaps exactly 1 pixpulse.
- MOVE_DIV=1, pause=1 during frame 2 only → move pulses in frames 0, 1, 3 and none in frame 2; hcount/vcount/frame_cnt unaffected.
- Assert rst asynchronously at hcount=300, vcount=100 → all outputs take reset values in the same cycle. After release, the first pixpulse is again the 4th clk and counts restart at (0,0).
